// File: rtl/wheel_state_buffer.sv
// wheel_state_buffer: owns the committed per-node wheel state and runs one
// physics timestep around update_wheel. It collects the streamed node
// positions and velocities into shadow storage, integrates position from
// velocity one node per cycle, and then commits both arrays on a single edge.
// Array layout: [node][axis][bits], where axis 0 is x and axis 1 is y. Values
// are two's complement; the packed ports are unsigned and get cast where the
// arithmetic needs them signed.
module wheel_state_buffer #(
    parameter int NUM_NODES     = 8,
    parameter int POSITION_SIZE = 16,
    parameter int VELOCITY_SIZE = 16,
    parameter int DT_SHIFT      = 4,
    parameter int TIMEOUT       = 4096
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic [NUM_NODES-1:0][1:0][POSITION_SIZE-1:0]  init_nodes,
    input  logic [NUM_NODES-1:0][1:0][VELOCITY_SIZE-1:0]  init_velocities,
    input  logic                                          step_in,
    input  logic [POSITION_SIZE-1:0]                      node_in_x,
    input  logic [POSITION_SIZE-1:0]                      node_in_y,
    input  logic                                          node_in_valid,
    input  logic [VELOCITY_SIZE-1:0]                      velocity_in_x,
    input  logic [VELOCITY_SIZE-1:0]                      velocity_in_y,
    input  logic                                          velocity_in_valid,
    input  logic                                          result_in,
    output logic [NUM_NODES-1:0][1:0][POSITION_SIZE-1:0]  nodes_out,
    output logic [NUM_NODES-1:0][1:0][VELOCITY_SIZE-1:0]  velocities_out,
    output logic                                          begin_out,
    output logic                                          busy_out,
    output logic                                          step_done_out,
    output logic                                          error_out,
    output logic [15:0]                                   step_count_out
);

    localparam int CW = $clog2(NUM_NODES + 1);
    localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    // The sum width keeps the shifted velocity and the position exact before
    // saturation, whatever the relative sizes of the two fields are.
    localparam int SW = ((POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE) + 2;

    localparam logic [CW-1:0]        FULL       = CW'(NUM_NODES);
    localparam logic [IW-1:0]        LAST_IDX   = IW'(NUM_NODES - 1);
    localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic signed [SW-1:0] POS_MAX    = SW'((64'sd1 <<< (POSITION_SIZE - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] POS_MIN    = ~POS_MAX;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_INTEGRATE, S_COMMIT} state_t;

    state_t                                        state_q, state_d;
    logic [CW-1:0]                                 node_cnt_q, vel_cnt_q;
    logic [TW-1:0]                                 timer_q;
    logic                                          overflow_q;
    logic [IW-1:0]                                 idx_q;
    logic                                          begin_q, step_done_q, error_q;
    logic [15:0]                                   step_count_q;
    logic [NUM_NODES-1:0][1:0][POSITION_SIZE-1:0]  nodes_q, shadow_pos_q;
    logic [NUM_NODES-1:0][1:0][VELOCITY_SIZE-1:0]  vels_q, shadow_vel_q;

    logic                   node_take, node_drop, vel_take, vel_drop;
    logic [CW-1:0]          node_cnt_d, vel_cnt_d;
    logic                   overflow_d, counts_ok, timeout_hit;
    logic [NUM_NODES-1:0]   pos_we, vel_we, int_we;
    logic [1:0][POSITION_SIZE-1:0] cur_pos, int_pos;
    logic [1:0][VELOCITY_SIZE-1:0] cur_vel;

    // Stream accounting; the counts include any valid landing with result_in.
    always_comb begin
        node_take   = (state_q == S_COLLECT) && node_in_valid && (node_cnt_q != FULL);
        node_drop   = (state_q == S_COLLECT) && node_in_valid && (node_cnt_q == FULL);
        vel_take    = (state_q == S_COLLECT) && velocity_in_valid && (vel_cnt_q != FULL);
        vel_drop    = (state_q == S_COLLECT) && velocity_in_valid && (vel_cnt_q == FULL);
        node_cnt_d  = node_cnt_q + CW'(node_take);
        vel_cnt_d   = vel_cnt_q + CW'(vel_take);
        overflow_d  = overflow_q | node_drop | vel_drop;
        counts_ok   = (node_cnt_d == FULL) && (vel_cnt_d == FULL) && !overflow_d;
        timeout_hit = (timer_q == TIMER_LAST);
    end

    // Next-state logic for the step sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (step_in) state_d = S_COLLECT;
            S_COLLECT: begin
                if (result_in)        state_d = counts_ok ? S_INTEGRATE : S_IDLE;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_INTEGRATE: if (idx_q == LAST_IDX) state_d = S_COMMIT;
            S_COMMIT:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Per-node shadow write enables: stream capture slot and integration slot.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_NODES; gi++) begin : g_node
            assign pos_we[gi] = node_take && (node_cnt_q == CW'(gi));
            assign vel_we[gi] = vel_take && (vel_cnt_q == CW'(gi));
            assign int_we[gi] = (state_q == S_INTEGRATE) && (idx_q == IW'(gi));
        end
    endgenerate

    assign cur_pos = shadow_pos_q[idx_q];
    assign cur_vel = shadow_vel_q[idx_q];

    // One saturating integrator per axis, shared across nodes via idx_q.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic signed [SW-1:0] pos_ext, vel_shift, sum;
            // pos + (vel >>> DT_SHIFT), clamped to the position range.
            always_comb begin
                pos_ext   = SW'($signed(cur_pos[gi]));
                vel_shift = SW'($signed(cur_vel[gi])) >>> DT_SHIFT;
                sum       = pos_ext + vel_shift;
                if (sum > POS_MAX)      int_pos[gi] = POS_MAX[POSITION_SIZE-1:0];
                else if (sum < POS_MIN) int_pos[gi] = POS_MIN[POSITION_SIZE-1:0];
                else                    int_pos[gi] = sum[POSITION_SIZE-1:0];
            end
        end
    endgenerate

    // Shadow storage: filled from the streams, then rewritten by integration.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_NODES; i++) begin
            if (pos_we[i])      shadow_pos_q[i] <= {node_in_y, node_in_x};
            else if (int_we[i]) shadow_pos_q[i] <= int_pos;
            if (vel_we[i])      shadow_vel_q[i] <= {velocity_in_y, velocity_in_x};
        end
    end

    // Sequencer state, counters, pulses and the committed arrays.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            node_cnt_q   <= '0;
            vel_cnt_q    <= '0;
            timer_q      <= '0;
            overflow_q   <= 1'b0;
            idx_q        <= '0;
            begin_q      <= 1'b0;
            step_done_q  <= 1'b0;
            error_q      <= 1'b0;
            step_count_q <= '0;
            nodes_q      <= init_nodes;
            vels_q       <= init_velocities;
        end else begin
            state_q     <= state_d;
            begin_q     <= (state_q == S_IDLE) && step_in;
            step_done_q <= (state_q == S_COMMIT);
            case (state_q)
                S_IDLE: begin
                    if (step_in) begin
                        node_cnt_q <= '0;
                        vel_cnt_q  <= '0;
                        timer_q    <= '0;
                        overflow_q <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    node_cnt_q <= node_cnt_d;
                    vel_cnt_q  <= vel_cnt_d;
                    overflow_q <= overflow_d;
                    timer_q    <= timer_q + TW'(1);
                    idx_q      <= '0;
                    if ((result_in && !counts_ok) || (!result_in && timeout_hit))
                        error_q <= 1'b1;
                end
                S_INTEGRATE: idx_q <= idx_q + IW'(1);
                S_COMMIT: begin
                    nodes_q      <= shadow_pos_q;
                    vels_q       <= shadow_vel_q;
                    step_count_q <= step_count_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign nodes_out      = nodes_q;
    assign velocities_out = vels_q;
    assign begin_out      = begin_q;
    assign busy_out       = (state_q != S_IDLE);
    assign step_done_out  = step_done_q;
    assign error_out      = error_q;
    assign step_count_out = step_count_q;

endmodule
